id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between Decode and Execute in the 5-stage MIPS pipeline.
- Captures the decoded control bundle (RegDst, ALU_Src, MemtoReg, RegWrite, MemRead, MemWrite, ALU_op, branch, jump) together with operands and register addresses.
- Owns load-use hazard detection: on a hazard it stalls PC and IF/ID and inserts a bubble.
- Handles flush from branch/jump resolution, holds on a downstream stall, and keeps a saturating bubble counter.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register address width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  Decode holds a real instruction
- id_RegDst, id_ALU_Src, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_branch, id_jump  in  1 each  control from decoder
- id_ALU_op  in  2  ALU op class from decoder
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of the Decode instruction
- id_rs, id_rt, id_rd  in  REG_W  register addresses
- id_funct  in  6  instr[5:0]
- flush  in  1  taken branch/jump, kill the Decode instruction
- ex_stall  in  1  downstream hold request
- ex_valid  out  1  EX holds a real instruction
- ex_RegDst, ex_ALU_Src, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_branch, ex_jump  out  1 each  registered control
- ex_ALU_op  out  2  registered ALU op
- ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W  registered operands
- ex_rs, ex_rt, ex_rd  out  REG_W  registered addresses
- ex_funct  out  6  registered funct
- pc_write  out  1  0 freezes PC
- if_id_write  out  1  0 freezes IF/ID register
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (async, immediate): every registered output = 0. ex_ALU_op = 2'b00, never X. bubble_cnt = 0.
- Hazard detection, combinational:
  - load_use = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- Upstream enables, combinational:
  - pc_write = if_id_write = ~(load_use | ex_stall) | flush.
  - Flush releases the freeze so the fetch redirect proceeds.
- Per rising edge, priority high to low:
  1. flush: load a bubble. All control = 0, ALU_op = 0, ex_valid = 0. Data/address fields are don't-care but must be driven to 0.
  2. ex_stall: hold every register unchanged. No bubble is counted.
  3. load_use: load a bubble as in (1). The Decode instruction is retained upstream and re-presented the next cycle.
  4. Otherwise: capture all id_* fields.
     - ex_valid = id_valid.
     - If id_valid = 0, all control bits are forced to 0.
- bubble_cnt:
  - Increments by 1 on each edge where case (1) or case (3) loads a bubble.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Latency: exactly one cycle from Decode to EX outputs when no stall or flush.
- Timing: no combinational path from id_* data inputs to ex_* outputs.
- Unknown-opcode bubbles from the decoder (all control 0) pass through as valid no-ops.
- flush + load_use in the same cycle: flush wins. Bubble is counted once, and pc_write = 1.
- flush + ex_stall in the same cycle: flush wins and the register loads a bubble.
- Reset asserted mid-stall: outputs clear immediately. After release, pc_write = 1 because ex_valid = 0.
- Load whose destination is $0 (ex_rt = 0): no hazard, no stall.
- Back-to-back loads to the same rt: each produces at most one bubble, because the bubble clears ex_MemRead.

Test Plan:
- Reset mid-run with rst = 1 asynchronously between edges → all ex_* = 0 and bubble_cnt = 0 before the next clk edge; pc_write = 1.
- R-type ADD (id_RegWrite = 1, ALU_op = 2'b10, rs = 8, rt = 9, rd = 10) with no hazard → next edge ex_ALU_op = 2'b10, ex_rd = 10, ex_valid = 1; pc_write stays 1.
- LW $9 in EX (ex_MemRead = 1, ex_rt = 9) with ADD using rs = 9 in ID → pc_write = if_id_write = 0 that cycle; next edge ex_valid = 0 with all control 0 and bubble_cnt = 1; following edge ADD captured.
- LW to $0 followed by a use of $0 → no stall, bubble_cnt unchanged.
- flush and load_use asserted together → bubble loaded, pc_write = 1, bubble_cnt increments by exactly 1.
- ex_stall = 1 for 3 cycles while a BEQ (branch = 1, ALU_op = 2'b01) sits in EX → EX outputs constant and pc_write = 0 for 3 cycles; bubble_cnt unchanged.
- Saturation: force 65535 bubbles with CNT_W = 16 → bubble_cnt holds 16'hFFFF on further bubbles.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline: captures decode control and
// operands, detects load-use hazards, handles flush/stall and counts inserted bubbles.
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_RegDst,
   input  logic              id_ALU_Src,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_branch,
   input  logic              id_jump,
   input  logic [1:0]        id_ALU_op,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [5:0]        id_funct,
   input  logic              flush,
   input  logic              ex_stall,
   output logic              ex_valid,
   output logic              ex_RegDst,
   output logic              ex_ALU_Src,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic [1:0]        ex_ALU_op,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic [5:0]        ex_funct,
   output logic              pc_write,
   output logic              if_id_write,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef struct packed {
      logic              valid;
      logic              reg_dst;
      logic              alu_src;
      logic              mem_to_reg;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              branch;
      logic              jump;
      logic [1:0]        alu_op;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc4;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [5:0]        funct;
   } ex_bundle_t;

   ex_bundle_t       ex_q, ex_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;
   logic             bubble;

   assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) && id_valid &&
                     ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));

   // Flush overrides the freeze so the fetch redirect is not lost.
   assign pc_write    = !(load_use || ex_stall) || flush;
   assign if_id_write = pc_write;

   always_comb begin
      ex_d   = ex_q;
      bubble = 1'b0;
      if (flush) begin
         ex_d   = '0;
         bubble = 1'b1;
      end else if (!ex_stall) begin
         if (load_use) begin
            ex_d   = '0;
            bubble = 1'b1;
         end else begin
            ex_d.valid      = id_valid;
            ex_d.reg_dst    = id_RegDst   && id_valid;
            ex_d.alu_src    = id_ALU_Src  && id_valid;
            ex_d.mem_to_reg = id_MemtoReg && id_valid;
            ex_d.reg_write  = id_RegWrite && id_valid;
            ex_d.mem_read   = id_MemRead  && id_valid;
            ex_d.mem_write  = id_MemWrite && id_valid;
            ex_d.branch     = id_branch   && id_valid;
            ex_d.jump       = id_jump     && id_valid;
            ex_d.alu_op     = id_valid ? id_ALU_op : 2'b00;
            ex_d.rs_data    = id_rs_data;
            ex_d.rt_data    = id_rt_data;
            ex_d.imm        = id_imm;
            ex_d.pc4        = id_pc4;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = id_rd;
            ex_d.funct      = id_funct;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bubble && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_RegDst   = ex_q.reg_dst;
   assign ex_ALU_Src  = ex_q.alu_src;
   assign ex_MemtoReg = ex_q.mem_to_reg;
   assign ex_RegWrite = ex_q.reg_write;
   assign ex_MemRead  = ex_q.mem_read;
   assign ex_MemWrite = ex_q.mem_write;
   assign ex_branch   = ex_q.branch;
   assign ex_jump     = ex_q.jump;
   assign ex_ALU_op   = ex_q.alu_op;
   assign ex_rs_data  = ex_q.rs_data;
   assign ex_rt_data  = ex_q.rt_data;
   assign ex_imm      = ex_q.imm;
   assign ex_pc4      = ex_q.pc4;
   assign ex_rs       = ex_q.rs;
   assign ex_rt       = ex_q.rt;
   assign ex_rd       = ex_q.rd;
   assign ex_funct    = ex_q.funct;
   assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts the EX bundle, the
// upstream enables and the bubble counter for every cycle.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic        RegDst;
      logic        ALU_Src;
      logic        MemtoReg;
      logic        RegWrite;
      logic        MemRead;
      logic        MemWrite;
      logic        branch;
      logic        jump;
      logic [1:0]  ALU_op;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
   } ex_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        ex_stall;
   ex_t         idv;
   ex_t         exo;
   logic        pc_write, if_id_write;
   logic [15:0] bubble_cnt;

   logic ex_valid, ex_RegDst, ex_ALU_Src, ex_MemtoReg, ex_RegWrite;
   logic ex_MemRead, ex_MemWrite, ex_branch, ex_jump;
   logic [1:0]  ex_ALU_op;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [5:0]  ex_funct;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   ex_t         model;
   logic [15:0] mcnt;
   ex_t         sb[$];

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(idv.valid),
      .id_RegDst(idv.RegDst), .id_ALU_Src(idv.ALU_Src), .id_MemtoReg(idv.MemtoReg),
      .id_RegWrite(idv.RegWrite), .id_MemRead(idv.MemRead), .id_MemWrite(idv.MemWrite),
      .id_branch(idv.branch), .id_jump(idv.jump), .id_ALU_op(idv.ALU_op),
      .id_rs_data(idv.rs_data), .id_rt_data(idv.rt_data), .id_imm(idv.imm), .id_pc4(idv.pc4),
      .id_rs(idv.rs), .id_rt(idv.rt), .id_rd(idv.rd), .id_funct(idv.funct),
      .flush(flush), .ex_stall(ex_stall),
      .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ALU_Src(ex_ALU_Src),
      .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_ALU_op(ex_ALU_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_funct(ex_funct), .pc_write(pc_write), .if_id_write(if_id_write),
      .bubble_cnt(bubble_cnt)
   );

   always_comb begin
      exo = '{valid: ex_valid, RegDst: ex_RegDst, ALU_Src: ex_ALU_Src, MemtoReg: ex_MemtoReg,
              RegWrite: ex_RegWrite, MemRead: ex_MemRead, MemWrite: ex_MemWrite,
              branch: ex_branch, jump: ex_jump, ALU_op: ex_ALU_op, rs_data: ex_rs_data,
              rt_data: ex_rt_data, imm: ex_imm, pc4: ex_pc4, rs: ex_rs, rt: ex_rt,
              rd: ex_rd, funct: ex_funct};
   end

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ex_t rand_data(input ex_t base);
      ex_t r = base;
      r.rs_data = $urandom;
      r.rt_data = $urandom;
      r.imm     = $urandom;
      r.pc4     = $urandom & 32'hFFFF_FFFC;
      r.funct   = 6'($urandom);
      return r;
   endfunction

   // Inputs are set at the negedge; predicts, checks enables, then checks the edge result.
   task automatic step(input string tag);
      ex_t  nxt;
      ex_t  e;
      logic lu, bub, exp_pw;
      #1;
      lu = model.valid && model.MemRead && (model.rt != 5'd0) && idv.valid &&
           ((model.rt == idv.rs) || (model.rt == idv.rt));
      exp_pw = !(lu || ex_stall) || flush;
      check({tag, ".pc_write"}, 160'(pc_write), 160'(exp_pw));
      check({tag, ".if_id_write"}, 160'(if_id_write), 160'(exp_pw));
      bub = 1'b0;
      if (flush) begin
         nxt = '0;
         bub = 1'b1;
      end else if (ex_stall) begin
         nxt = model;
      end else if (lu) begin
         nxt = '0;
         bub = 1'b1;
      end else begin
         nxt = idv;
         if (!idv.valid) begin
            {nxt.RegDst, nxt.ALU_Src, nxt.MemtoReg, nxt.RegWrite} = 4'b0;
            {nxt.MemRead, nxt.MemWrite, nxt.branch, nxt.jump} = 4'b0;
            nxt.ALU_op = 2'b00;
         end
      end
      if (bub && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      sb.push_back(nxt);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, ".ex"}, 160'(exo), 160'(e));
      check({tag, ".bubble_cnt"}, 160'(bubble_cnt), 160'(mcnt));
      model = e;
      @(negedge clk);
   endtask

   function automatic ex_t lw(input logic [4:0] rs, input logic [4:0] rt);
      ex_t r = rand_data('0);
      r.valid = 1'b1; r.ALU_Src = 1'b1; r.MemtoReg = 1'b1; r.RegWrite = 1'b1;
      r.MemRead = 1'b1; r.rs = rs; r.rt = rt; r.rd = 5'($urandom);
      return r;
   endfunction

   function automatic ex_t add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      ex_t r = rand_data('0);
      r.valid = 1'b1; r.RegDst = 1'b1; r.RegWrite = 1'b1; r.ALU_op = 2'b10;
      r.rs = rs; r.rt = rt; r.rd = rd; r.funct = 6'h20;
      return r;
   endfunction

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ex_t add9;
      ex_t beq;
      rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; idv = '0;
      model = '0; mcnt = '0;
      #2;
      check("reset.ex", 160'(exo), 160'(0));
      check("reset.cnt", 160'(bubble_cnt), 160'(0));
      check("reset.pc_write", 160'(pc_write), 160'(1));
      @(negedge clk);
      rst = 1'b0;

      idv = add(5'd8, 5'd9, 5'd10);
      step("add");
      check("add.alu_op", 160'(ex_ALU_op), 160'(2'b10));
      check("add.rd", 160'(ex_rd), 160'(10));

      idv = lw(5'd1, 5'd9);
      step("lw9");
      add9 = add(5'd9, 5'd3, 5'd4);
      idv = add9;
      step("lu_bubble");
      check("lu_bubble.valid", 160'(ex_valid), 160'(0));
      step("lu_capture");

      idv = lw(5'd2, 5'd0);
      step("lw0");
      idv = add(5'd0, 5'd0, 5'd5);
      step("use0");

      idv = lw(5'd1, 5'd9);
      step("lw9b");
      idv = add(5'd3, 5'd9, 5'd6);
      flush = 1'b1;
      step("flush_lu");
      flush = 1'b0;

      beq = rand_data('0);
      beq.valid = 1'b1; beq.branch = 1'b1; beq.ALU_op = 2'b01; beq.rs = 5'd4; beq.rt = 5'd5;
      idv = beq;
      step("beq");
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idv = add(5'(i), 5'd7, 5'd8);
         step("stall");
      end
      check("stall.branch", 160'(ex_branch), 160'(1));

      flush = 1'b1;
      step("flush_stall");
      flush = 1'b0;
      ex_stall = 1'b0;

      idv = add(5'd1, 5'd2, 5'd3);
      idv.valid = 1'b0; idv.MemWrite = 1'b1; idv.jump = 1'b1;
      step("invalid");

      for (int i = 0; i < 300; i++) begin
         ex_t r = rand_data('0);
         {r.valid, r.RegDst, r.ALU_Src, r.MemtoReg, r.RegWrite} = 5'($urandom);
         {r.MemWrite, r.branch, r.jump} = 3'($urandom);
         r.MemRead = ($urandom_range(0, 9) < 4);
         r.valid   = ($urandom_range(0, 9) < 8);
         r.ALU_op  = 2'($urandom);
         r.rs = 5'($urandom_range(0, 3));
         r.rt = 5'($urandom_range(0, 3));
         r.rd = 5'($urandom);
         idv = r;
         flush    = ($urandom_range(0, 9) == 0);
         ex_stall = ($urandom_range(0, 6) == 0);
         step("rand");
      end
      flush = 1'b0; ex_stall = 1'b0;

      idv = beq;
      step("pre_rst");
      ex_stall = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("midrst.ex", 160'(exo), 160'(0));
      check("midrst.cnt", 160'(bubble_cnt), 160'(0));
      ex_stall = 1'b0;
      #1;
      check("midrst.pc_write", 160'(pc_write), 160'(1));
      @(negedge clk);
      rst = 1'b0;
      model = '0; mcnt = '0; sb.delete();

      flush = 1'b1;
      idv = add(5'd1, 5'd2, 5'd3);
      repeat (65534) @(negedge clk);
      mcnt = 16'd65534;
      step("sat_reach");
      check("sat_reach.max", 160'(bubble_cnt), 160'(16'hFFFF));
      step("sat_hold");
      flush = 1'b0;
      idv = lw(5'd1, 5'd9);
      step("sat_lw");
      idv = add(5'd9, 5'd1, 5'd2);
      step("sat_lu");
      check("sat_lu.max", 160'(bubble_cnt), 160'(16'hFFFF));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
